// File: rtl/bcd_sum_pkg.sv
// Shared constants for the BCD summator scheduler.
// Register map of the summator slave and scheduler FSM state codes.
package bcd_sum_pkg;

  localparam int unsigned SUM_ARG1_OFS     = 0;
  localparam int unsigned SUM_ARG2_OFS     = 4;
  localparam int unsigned SUM_RES_OFS      = 8;
  localparam int unsigned SUM_STATUS_OFS   = 12;
  localparam int unsigned SUM_STATUS_START = 1;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_GRANT    = 4'd1;
  localparam state_t S_WR_A     = 4'd2;
  localparam state_t S_WR_B     = 4'd3;
  localparam state_t S_WR_GO    = 4'd4;
  localparam state_t S_RD_RES   = 4'd5;
  localparam state_t S_POLL_GAP = 4'd6;
  localparam state_t S_RD_ST    = 4'd7;
  localparam state_t S_RESP     = 4'd8;

endpackage

// File: rtl/bcd_sum_scheduler_arb.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Outputs a one-hot grant, the winner index and an any-grant flag.
module rr_arbiter
  import bcd_sum_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               gnt_any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        idx     = j;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_sum_scheduler.sv
// APB master sharing one BCD summator between NUM_REQ requesters.
// Define BCD_SCHED_TIMEOUT_EN to add a pready watchdog on ACCESS.
module bcd_sum_scheduler
  import bcd_sum_pkg::*;
#(
  parameter int          NUM_REQ          = 4,
  parameter int unsigned summatorBaseAddr = 0,
  parameter int          addrWidth        = 32,
  parameter int          dataWidth        = 32,
  parameter int          maxPoll          = 15,
  parameter int          timeoutCycles    = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*dataWidth-1:0] req_arg1,
  input  logic [NUM_REQ*dataWidth-1:0] req_arg2,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [dataWidth-1:0]         rsp_sum,
  output logic                         rsp_overflow,
  output logic                         rsp_error,
  output logic                         aps_psel,
  output logic                         aps_penable,
  output logic                         aps_pwrite,
  output logic [addrWidth-1:0]         aps_paddr,
  output logic [dataWidth-1:0]         aps_pwdata,
  input  logic [dataWidth-1:0]         aps_prdata,
  input  logic                         aps_pready,
  input  logic                         aps_pslverr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(maxPoll + 2);

  state_t               state;
  logic                 acc;
  logic [IW-1:0]        rr_ptr;
  logic [dataWidth-1:0] arg_a;
  logic [dataWidth-1:0] arg_b;
  logic [PW-1:0]        poll_cnt;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gidx;
  logic                 gany;
  logic                 xfer;
  logic                 wr;
  logic                 done;
  logic                 to_hit;
  logic [addrWidth-1:0] ofs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .idx     (gidx),
    .gnt_any (gany)
  );

  always_comb begin
    xfer       = 1'b0;
    wr         = 1'b0;
    ofs        = '0;
    aps_pwdata = '0;
    unique case (state)
      S_WR_A: begin
        xfer       = 1'b1;
        wr         = 1'b1;
        ofs        = addrWidth'(SUM_ARG1_OFS);
        aps_pwdata = arg_a;
      end
      S_WR_B: begin
        xfer       = 1'b1;
        wr         = 1'b1;
        ofs        = addrWidth'(SUM_ARG2_OFS);
        aps_pwdata = arg_b;
      end
      S_WR_GO: begin
        xfer       = 1'b1;
        wr         = 1'b1;
        ofs        = addrWidth'(SUM_STATUS_OFS);
        aps_pwdata = dataWidth'(SUM_STATUS_START);
      end
      S_RD_RES: begin
        xfer = 1'b1;
        ofs  = addrWidth'(SUM_RES_OFS);
      end
      S_RD_ST: begin
        xfer = 1'b1;
        ofs  = addrWidth'(SUM_STATUS_OFS);
      end
      default: ;
    endcase
  end

  assign aps_psel    = xfer;
  assign aps_penable = xfer & acc;
  assign aps_pwrite  = wr;
  assign aps_paddr   = xfer ? addrWidth'(summatorBaseAddr) + ofs : '0;
  assign done        = aps_penable & aps_pready;
  assign req_ready   = (state == S_GRANT) ? gnt : '0;
  assign rsp_valid   = (state == S_RESP);

`ifdef BCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(timeoutCycles + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || !aps_penable || aps_pready)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = aps_penable && !aps_pready &&
                  (to_cnt == TW'(timeoutCycles - 1));
`else
  localparam int unused_timeout = timeoutCycles;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      acc          <= 1'b0;
      rr_ptr       <= '0;
      arg_a        <= '0;
      arg_b        <= '0;
      poll_cnt     <= '0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
      rsp_error    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (|req_valid) state <= S_GRANT;
        S_GRANT: begin
          if (gany) begin
            rsp_id       <= gidx;
            arg_a        <= req_arg1[gidx*dataWidth +: dataWidth];
            arg_b        <= req_arg2[gidx*dataWidth +: dataWidth];
            rr_ptr       <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
            rsp_sum      <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
            poll_cnt     <= '0;
            acc          <= 1'b0;
            state        <= S_WR_A;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WR_A, S_WR_B, S_WR_GO, S_RD_RES, S_RD_ST: begin
          if (!acc) begin
            acc <= 1'b1;
          end else if (done) begin
            acc <= 1'b0;
            if (wr && aps_pslverr) begin
              rsp_error <= 1'b1;
              state     <= S_RESP;
            end else begin
              unique case (state)
                S_WR_A:  state <= S_WR_B;
                S_WR_B:  state <= S_WR_GO;
                S_WR_GO: state <= S_RD_RES;
                S_RD_RES: begin
                  if (!aps_pslverr) begin
                    rsp_sum <= aps_prdata;
                    state   <= S_RD_ST;
                  end else if (poll_cnt == PW'(maxPoll)) begin
                    rsp_error <= 1'b1;
                    state     <= S_RESP;
                  end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                    state    <= S_POLL_GAP;
                  end
                end
                default: begin
                  rsp_overflow <= aps_prdata[0];
                  state        <= S_RESP;
                end
              endcase
            end
          end else if (to_hit) begin
            // watchdog abandons the job; any partial sum is not reported
            acc       <= 1'b0;
            rsp_sum   <= '0;
            rsp_error <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_POLL_GAP: state <= S_RD_RES;
        S_RESP:     state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sum_scheduler.sv
// Bench for bcd_sum_scheduler: APB summator stub plus decimal reference model.
// Honours BCD_SCHED_TIMEOUT_EN for the stuck-pready scenario.
module tb_bcd_sum_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_arg1 = '0;
  logic [N*DW-1:0] req_arg2 = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_sum;
  logic            rsp_overflow;
  logic            rsp_error;
  logic            aps_psel;
  logic            aps_penable;
  logic            aps_pwrite;
  logic [AW-1:0]   aps_paddr;
  logic [DW-1:0]   aps_pwdata;
  logic [DW-1:0]   aps_prdata;
  logic            aps_pready = 1'b0;
  logic            aps_pslverr;

  bcd_sum_scheduler #(
    .NUM_REQ          (N),
    .summatorBaseAddr (0),
    .addrWidth        (AW),
    .dataWidth        (DW),
    .maxPoll          (15),
    .timeoutCycles    (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_arg1     (req_arg1),
    .req_arg2     (req_arg2),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error),
    .aps_psel     (aps_psel),
    .aps_penable  (aps_penable),
    .aps_pwrite   (aps_pwrite),
    .aps_paddr    (aps_paddr),
    .aps_pwdata   (aps_pwdata),
    .aps_prdata   (aps_prdata),
    .aps_pready   (aps_pready),
    .aps_pslverr  (aps_pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: treat operands as decimal numbers
  function automatic longint bcd2int(input logic [31:0] x);
    longint v = 0;
    for (int i = 7; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [32:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b);
    longint s;
    logic [32:0] r;
    s = bcd2int(a) + bcd2int(b);
    r[32] = (s >= 64'd100000000);
    s = s % 100000000;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] rbcd();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // summator slave stub: digit-serial adder with carry
  function automatic logic [32:0] slave_add(input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] r;
    logic [4:0]  d;
    logic        c = 1'b0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, c};
      c = (d > 5'd9);
      if (c) d = d - 5'd10;
      r[i*4 +: 4] = d[3:0];
    end
    r[32] = c;
    return r;
  endfunction

  bit          never_ready = 1'b0;
  bit          rand_wait   = 1'b0;
  int          res_err_max = 0;
  int          res_err_seen = 0;
  logic [31:0] wr_err_addr = '1;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [31:0] s_res = '0;
  logic        s_ovf = 1'b0;
  logic [31:0] addr_q[$];

  always @(negedge clk)
    aps_pready <= never_ready ? 1'b0 :
                  (rand_wait ? 1'($urandom % 2) : 1'b1);

  always_comb begin
    aps_prdata  = '0;
    aps_pslverr = 1'b0;
    if (aps_psel && aps_penable) begin
      if (aps_pwrite && aps_paddr == wr_err_addr) aps_pslverr = 1'b1;
      if (!aps_pwrite && aps_paddr == 32'd8) begin
        if (res_err_seen < res_err_max) aps_pslverr = 1'b1;
        else aps_prdata = s_res;
      end
      if (!aps_pwrite && aps_paddr == 32'd12) aps_prdata = {31'b0, s_ovf};
    end
  end

  always @(posedge clk) begin
    if (aps_psel && aps_penable && aps_pready) begin
      addr_q.push_back(aps_paddr);
      if (aps_pwrite && !aps_pslverr) begin
        if (aps_paddr == 32'd0) s_a <= aps_pwdata;
        if (aps_paddr == 32'd4) s_b <= aps_pwdata;
        if (aps_paddr == 32'd12 && aps_pwdata[0]) begin
          {s_ovf, s_res} <= slave_add(s_a, s_b);
          res_err_seen   <= 0;
        end
      end else if (!aps_pwrite && aps_paddr == 32'd8 && aps_pslverr) begin
        res_err_seen <= res_err_seen + 1;
      end
    end
  end

  int t_grant;
  int t_rsp;
  bit rdy_seen;

  task automatic wait_grant(output int w);
    w = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) w = k;
        t_grant = cyc;
        break;
      end
    end
    if (w < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready != '0) rdy_seen = 1'b1;
      if (rsp_valid) begin
        ok = 1'b1;
        t_rsp = cyc;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic check_rsp(input int id, input logic [31:0] a,
                           input logic [31:0] b, input bit exp_err);
    logic [32:0] r;
    r = exp_err ? 33'b0 : ref_add(a, b);
    chk("rsp_id", rsp_id, id);
    chk("rsp_sum", rsp_sum, r[31:0]);
    chk("rsp_ovf", rsp_overflow, r[32]);
    chk("rsp_err", rsp_error, exp_err);
  endtask

  task automatic run_job(input int id, input logic [31:0] a,
                         input logic [31:0] b, input bit exp_err,
                         input int gaps, input int exp_lat);
    int          w;
    bit          ok;
    int          bad;
    logic [31:0] exp_q[$];
    req_arg1[id*DW +: DW] = a;
    req_arg2[id*DW +: DW] = b;
    req_valid[id] = 1'b1;
    wait_grant(w);
    if (w < 0) begin
      req_valid[id] = 1'b0;
      return;
    end
    chk("gnt_onehot", req_ready, 64'(1) << id);
    addr_q.delete();
    @(negedge clk);
    req_valid[id] = 1'b0;
    wait_rsp(ok);
    if (!ok) return;
    check_rsp(id, a, b, exp_err);
    if (exp_lat >= 0) chk("latency", t_rsp - t_grant, exp_lat);
    if (!exp_err) begin
      exp_q = '{32'd0, 32'd4, 32'd12};
      for (int i = 0; i <= gaps; i++) exp_q.push_back(32'd8);
      exp_q.push_back(32'd12);
      chk("addr_cnt", addr_q.size(), exp_q.size());
      bad = 0;
      foreach (exp_q[i])
        if (i >= addr_q.size() || addr_q[i] != exp_q[i]) bad++;
      chk("addr_order", bad, 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int          w;
    int          cnt;
    bit          ok;
    logic [31:0] a0;
    logic [31:0] a0b;
    logic [31:0] a2;

    repeat (2) @(negedge clk);
    chk("rst_apb", {aps_psel, aps_penable, aps_pwrite}, 0);
    chk("rst_paddr", aps_paddr, 0);
    chk("rst_pwdata", aps_pwdata, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_overflow, rsp_error, rsp_id}, 0);
    chk("rst_sum", rsp_sum, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_psel", aps_psel, 0);

    run_job(0, 32'h25, 32'h30, 1'b0, 0, 11);
    run_job(1, 32'h60308002, 32'h51406555, 1'b0, 0, 11);
    run_job(2, 32'h99999999, 32'h00000001, 1'b0, 0, 11);

    // arbitration from rr_ptr = 0
    do_reset();
    a0  = 32'h12345678;
    a0b = 32'h00000999;
    a2  = 32'h87654321;
    req_arg1[0 +: DW]    = a0;
    req_arg2[0 +: DW]    = a0;
    req_arg1[2*DW +: DW] = a2;
    req_arg2[2*DW +: DW] = 32'h11111111;
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    wait_grant(w);
    chk("arb_first", w, 0);
    @(negedge clk);
    req_arg1[0 +: DW] = a0b;
    req_arg2[0 +: DW] = a0b;
    wait_rsp(ok);
    chk("holdoff", rdy_seen, 0);
    if (ok) check_rsp(0, a0, a0, 1'b0);
    wait_grant(w);
    chk("arb_second", w, 2);
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_rsp(ok);
    if (ok) check_rsp(2, a2, 32'h11111111, 1'b0);
    wait_grant(w);
    chk("arb_third", w, 0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(ok);
    if (ok) check_rsp(0, a0b, a0b, 1'b0);

    res_err_max = 3;
    run_job(3, rbcd(), rbcd(), 1'b0, 3, 20);
    res_err_max = 16;
    run_job(1, rbcd(), rbcd(), 1'b1, 0, 54);
    res_err_max = 0;
    wr_err_addr = 32'd4;
    run_job(2, rbcd(), rbcd(), 1'b1, 0, 5);
    wr_err_addr = '1;

    rand_wait = 1'b1;
    repeat (10) run_job(int'($urandom_range(0, N - 1)), rbcd(), rbcd(),
                        1'b0, 0, -1);
    rand_wait = 1'b0;

    // reset while WR_B is in ACCESS
    req_arg1[DW +: DW] = 32'h1;
    req_arg2[DW +: DW] = 32'h2;
    req_valid[1] = 1'b1;
    wait_grant(w);
    @(negedge clk);
    req_valid[1] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (aps_penable && aps_paddr == 32'd4) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wrb_seen", ok, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_psel", {aps_psel, aps_penable}, 0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("rst_no_rsp", cnt, 0);
    run_job(2, 32'h00004999, 32'h00000001, 1'b0, 0, 11);

    // slave never raises pready
    never_ready = 1'b1;
`ifdef BCD_SCHED_TIMEOUT_EN
    run_job(3, 32'h11, 32'h22, 1'b1, 0, TO + 2);
    chk("to_psel", aps_psel, 0);
    never_ready = 1'b0;
`else
    req_valid[3] = 1'b1;
    wait_grant(w);
    @(negedge clk);
    req_valid[3] = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("stuck_psel", {aps_psel, aps_penable}, 2'b11);
    chk("stuck_no_rsp", cnt, 0);
    never_ready = 1'b0;
    do_reset();
`endif
    run_job(1, 32'h50000000, 32'h50000000, 1'b0, 0, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
